// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word collector.
// Frame length depends on the PARITY_EN build option (see serial_word_collector.sv).
package serial_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } col_state_t;

    function automatic int frame_bits(input int width, input bit parity);
        if (parity) begin
            return width + 1;
        end else begin
            return width;
        end
    endfunction

    // Even parity over the data bits: a set result means the trailing bit disagrees.
    function automatic logic parity_fail(input logic [15:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Bundle of the serial input strobes and the word-output handshake.
// PAR_ERR exists only when PARITY_EN is defined.
interface serial_word_collector_if #(parameter int WIDTH = 4);

    logic             si;
    logic             sh;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic             overrun;
`ifdef PARITY_EN
    logic             par_err;

    modport master (input si, sh, start, ready, output dout, valid, busy, overrun, par_err);
    modport slave  (output si, sh, start, ready, input dout, valid, busy, overrun, par_err);
`else
    modport master (input si, sh, start, ready, output dout, valid, busy, overrun);
    modport slave  (output si, sh, start, ready, input dout, valid, busy, overrun);
`endif

endinterface

// File: rtl/word_out_reg.sv
// One-entry output register with VALID/READY handshake and sticky OVERRUN.
// Carries the parity-error flag alongside the word when PARITY_EN is defined.
module word_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef PARITY_EN
    input  logic             load_perr,
    output logic             par_err,
`endif
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_r;
    logic             valid_r;
    logic             overrun_r;
    logic             take_s;
    logic             drop_s;
`ifdef PARITY_EN
    logic             perr_r;
`endif

    // A completed word is taken if the slot is free or being emptied on this edge.
    always_comb begin
        take_s = 1'b0;
        drop_s = 1'b0;
        if (load) begin
            take_s = !valid_r || ready;
            drop_s = valid_r && !ready;
        end else begin
            take_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Output slot, handshake and sticky overrun state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
`ifdef PARITY_EN
            perr_r    <= 1'b0;
`endif
        end else begin
            if (take_s) begin
                dout_r  <= load_data;
                valid_r <= 1'b1;
`ifdef PARITY_EN
                perr_r  <= load_perr;
`endif
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end
            // A drop on the same edge as START must still leave the flag set.
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (start) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign dout    = dout_r;
    assign valid   = valid_r;
    assign overrun = overrun_r;
`ifdef PARITY_EN
    assign par_err = perr_r;
`endif

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles WIDTH-bit words from a strobed serial stream and hands them out via VALID/READY.
// Define PARITY_EN to append a trailing even-parity bit to each frame and report PAR_ERR.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_word_collector_if.master bus
);

`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int FRAME_BITS = frame_bits(WIDTH, PAR_ON);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    col_state_t            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_base_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [FRAME_BITS-1:0] shreg_r;
    logic [FRAME_BITS-1:0] shift_nxt_s;
    logic                  sample_s;
    logic                  done_s;
    logic [WIDTH-1:0]      word_s;
    logic [WIDTH-1:0]      dout_s;
    logic                  valid_s;
    logic                  overrun_s;
`ifdef PARITY_EN
    logic                  perr_s;
    logic                  par_err_s;
`endif

    // Sampling, bit counting and the word as it will look after this edge.
    always_comb begin
        sample_s   = bus.sh && ((state_r == S_COLLECT) || bus.start);
        cnt_base_s = bus.start ? {CNT_W{1'b0}} : cnt_r;
        if (sample_s) begin
            cnt_nxt_s = cnt_base_s + CNT_W'(1'b1);
        end else begin
            cnt_nxt_s = cnt_base_s;
        end
        done_s = sample_s && (cnt_nxt_s == FRAME_CNT);
        // Shifting a full frame through flushes any stale bits, so START needs no clear.
        if (LSB_FIRST) begin
            shift_nxt_s = {bus.si, shreg_r[FRAME_BITS-1:1]};
            word_s      = shift_nxt_s[WIDTH-1:0];
        end else begin
            shift_nxt_s = {shreg_r[FRAME_BITS-2:0], bus.si};
            word_s      = shift_nxt_s[FRAME_BITS-1 -: WIDTH];
        end
`ifdef PARITY_EN
        if (LSB_FIRST) begin
            perr_s = parity_fail(16'(word_s), shift_nxt_s[FRAME_BITS-1]);
        end else begin
            perr_s = parity_fail(16'(word_s), shift_nxt_s[0]);
        end
`endif
    end

    // Collection FSM, bit counter and assembly register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {FRAME_BITS{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (done_s) begin
                        state_r <= S_IDLE;
                    end else if (bus.start) begin
                        state_r <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (done_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            cnt_r <= done_s ? {CNT_W{1'b0}} : cnt_nxt_s;
            if (sample_s) begin
                shreg_r <= shift_nxt_s;
            end
        end
    end

    word_out_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (done_s),
        .load_data (word_s),
`ifdef PARITY_EN
        .load_perr (perr_s),
        .par_err   (par_err_s),
`endif
        .start     (bus.start),
        .ready     (bus.ready),
        .dout      (dout_s),
        .valid     (valid_s),
        .overrun   (overrun_s)
    );

    assign bus.dout    = dout_s;
    assign bus.valid   = valid_s;
    assign bus.overrun = overrun_s;
    assign bus.busy    = (state_r == S_COLLECT);
`ifdef PARITY_EN
    assign bus.par_err = par_err_s;
`endif

endmodule
